// File: rtl/led_ram_arbiter.sv
// Arbiter for the single-port 8x8 LED display RAM: a bulk-clear sequencer, handshaked pen
// writes and continuous scan reads share one port. All RAM pins and status outputs are registered.
module led_ram_arbiter #(
   parameter int unsigned N           = 8,
   parameter int unsigned DATA_W      = 4,
   parameter int unsigned PEN_HOLDOFF = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N-1:0]      scan_row,
   input  logic [N-1:0]      scan_col,
   input  logic              pen_req,
   input  logic [N-1:0]      pen_row,
   input  logic [N-1:0]      pen_col,
   input  logic [DATA_W-1:0] pen_data,
   output logic              pen_ack,
   output logic              pen_err,
   input  logic              clr_start,
   input  logic [DATA_W-1:0] clr_data,
   output logic              clr_busy,
   output logic              clr_done,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_data,
   output logic [N-1:0]      ram_row,
   output logic [N-1:0]      ram_col,
   output logic              scan_valid
);

   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned HW = $clog2(PEN_HOLDOFF + 1);

   typedef enum logic [0:0] {StIdle, StClear} state_e;

   state_e            state_q;
   logic [CW-1:0]     row_q, col_q;
   logic [CW-1:0]     row_nx, col_nx;
   logic [HW-1:0]     hold_q;
   logic [DATA_W-1:0] fill_q;
   logic              last_cell;
   logic              row_ok, col_ok;

   always_comb begin
      last_cell = (row_q == CW'(N - 1)) && (col_q == CW'(N - 1));
      col_nx    = (col_q == CW'(N - 1)) ? '0 : col_q + 1'b1;
      row_nx    = (col_q == CW'(N - 1)) ? row_q + 1'b1 : row_q;
      row_ok    = (pen_row != '0) && ((pen_row & (pen_row - 1'b1)) == '0);
      col_ok    = (pen_col != '0) && ((pen_col & (pen_col - 1'b1)) == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         row_q      <= '0;
         col_q      <= '0;
         hold_q     <= '0;
         fill_q     <= '0;
         pen_ack    <= 1'b0;
         pen_err    <= 1'b0;
         clr_busy   <= 1'b0;
         clr_done   <= 1'b0;
         ram_we     <= 1'b0;
         ram_data   <= '0;
         ram_row    <= '0;
         ram_col    <= '0;
         scan_valid <= 1'b0;
      end else begin
         pen_ack  <= 1'b0;
         pen_err  <= 1'b0;
         clr_done <= 1'b0;
         if (state_q == StClear && !last_cell) begin
            row_q      <= row_nx;
            col_q      <= col_nx;
            ram_we     <= 1'b1;
            ram_data   <= fill_q;
            ram_row    <= N'(1) << row_nx;
            ram_col    <= N'(1) << col_nx;
            scan_valid <= 1'b0;
         end else begin
            // Leaving CLEAR after the last cell: this edge is already an arbitrated IDLE slot.
            clr_done <= (state_q == StClear);
            clr_busy <= 1'b0;
            state_q  <= StIdle;
            if (clr_start) begin
               state_q    <= StClear;
               fill_q     <= clr_data;
               row_q      <= '0;
               col_q      <= '0;
               clr_busy   <= 1'b1;
               ram_we     <= 1'b1;
               ram_data   <= clr_data;
               ram_row    <= N'(1);
               ram_col    <= N'(1);
               scan_valid <= 1'b0;
            end else if (pen_req && hold_q == '0) begin
               pen_ack <= 1'b1;
               hold_q  <= HW'(PEN_HOLDOFF);
               if (row_ok && col_ok) begin
                  ram_we     <= 1'b1;
                  ram_data   <= pen_data;
                  ram_row    <= pen_row;
                  ram_col    <= pen_col;
                  scan_valid <= 1'b0;
               end else begin
                  pen_err    <= 1'b1;
                  ram_we     <= 1'b0;
                  ram_row    <= scan_row;
                  ram_col    <= scan_col;
                  scan_valid <= 1'b1;
               end
            end else begin
               ram_we     <= 1'b0;
               ram_row    <= scan_row;
               ram_col    <= scan_col;
               scan_valid <= 1'b1;
               if (hold_q != '0) begin
                  hold_q <= hold_q - 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_led_ram_arbiter.sv
// Randomized and directed bench for led_ram_arbiter, checked cycle by cycle against a
// transaction-level model of the arbitration rules plus a 64-cell RAM image.
module tb_led_ram_arbiter;

   localparam int N = 8;
   localparam int DW = 4;
   localparam int HOLD = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [N-1:0]  scan_row = 8'h01, scan_col = 8'h01;
   logic          pen_req = 1'b0;
   logic [N-1:0]  pen_row = '0, pen_col = '0;
   logic [DW-1:0] pen_data = '0;
   logic          pen_ack, pen_err;
   logic          clr_start = 1'b0;
   logic [DW-1:0] clr_data = '0;
   logic          clr_busy, clr_done;
   logic          ram_we;
   logic [DW-1:0] ram_data;
   logic [N-1:0]  ram_row, ram_col;
   logic          scan_valid;

   led_ram_arbiter #(.N(N), .DATA_W(DW), .PEN_HOLDOFF(HOLD)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .scan_row   (scan_row),
      .scan_col   (scan_col),
      .pen_req    (pen_req),
      .pen_row    (pen_row),
      .pen_col    (pen_col),
      .pen_data   (pen_data),
      .pen_ack    (pen_ack),
      .pen_err    (pen_err),
      .clr_start  (clr_start),
      .clr_data   (clr_data),
      .clr_busy   (clr_busy),
      .clr_done   (clr_done),
      .ram_we     (ram_we),
      .ram_data   (ram_data),
      .ram_row    (ram_row),
      .ram_col    (ram_col),
      .scan_valid (scan_valid)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Reference model state: clear progress as "next cell index", holdoff as remaining scan slots.
   bit            m_clearing;
   int            m_idx;
   int            m_hold;
   logic [DW-1:0] m_fill;

   logic          e_we, e_ack, e_err, e_done, e_busy, e_sv;
   logic [N-1:0]  e_row, e_col;
   logic [DW-1:0] e_data;

   logic [DW-1:0] dut_ram [64];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [N-1:0] onehot_rand();
      return N'(1) << $urandom_range(0, N - 1);
   endfunction

   task automatic model_reset();
      m_clearing = 0;
      m_idx      = 0;
      m_hold     = 0;
      m_fill     = '0;
   endtask

   task automatic model_edge();
      e_we = 0; e_ack = 0; e_err = 0; e_done = 0; e_busy = 0; e_sv = 0;
      e_row = '0; e_col = '0; e_data = '0;
      if (m_clearing && m_idx < 64) begin
         e_we   = 1;
         e_busy = 1;
         e_row  = N'(1) << (m_idx / 8);
         e_col  = N'(1) << (m_idx % 8);
         e_data = m_fill;
         m_idx++;
      end else begin
         if (m_clearing) begin
            e_done     = 1;
            m_clearing = 0;
         end
         if (clr_start) begin
            m_clearing = 1;
            m_fill     = clr_data;
            e_we = 1; e_busy = 1; e_row = 8'h01; e_col = 8'h01; e_data = clr_data;
            m_idx = 1;
         end else if (pen_req && m_hold == 0) begin
            e_ack  = 1;
            m_hold = HOLD;
            if ($countones(pen_row) == 1 && $countones(pen_col) == 1) begin
               e_we = 1; e_row = pen_row; e_col = pen_col; e_data = pen_data;
            end else begin
               e_err = 1; e_sv = 1; e_row = scan_row; e_col = scan_col;
            end
         end else begin
            e_sv  = 1;
            e_row = scan_row;
            e_col = scan_col;
            if (m_hold > 0) m_hold--;
         end
      end
   endtask

   // One clock: predict from the inputs about to be sampled, then compare #1 after the edge.
   task automatic step();
      int r, c;
      model_edge();
      @(posedge clk);
      #1;
      check("ram_we", 32'(ram_we), 32'(e_we));
      check("pen_ack", 32'(pen_ack), 32'(e_ack));
      check("pen_err", 32'(pen_err), 32'(e_err));
      check("clr_busy", 32'(clr_busy), 32'(e_busy));
      check("clr_done", 32'(clr_done), 32'(e_done));
      check("scan_valid", 32'(scan_valid), 32'(e_sv));
      if (e_we || e_sv) begin
         check("ram_row", 32'(ram_row), 32'(e_row));
         check("ram_col", 32'(ram_col), 32'(e_col));
      end
      if (e_we) check("ram_data", 32'(ram_data), 32'(e_data));
      if (ram_we && $countones(ram_row) == 1 && $countones(ram_col) == 1) begin
         r = 0; c = 0;
         for (int i = 0; i < N; i++) begin
            if (ram_row[i]) r = i;
            if (ram_col[i]) c = i;
         end
         dut_ram[r*8 + c] = ram_data;
      end
      if (pen_ack) pen_req = 1'b0;
      clr_start = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_we"}, 32'(ram_we), 0);
      check({tag, "_data"}, 32'(ram_data), 0);
      check({tag, "_row"}, 32'(ram_row), 0);
      check({tag, "_col"}, 32'(ram_col), 0);
      check({tag, "_sv"}, 32'(scan_valid), 0);
      check({tag, "_ack"}, 32'(pen_ack), 0);
      check({tag, "_err"}, 32'(pen_err), 0);
      check({tag, "_busy"}, 32'(clr_busy), 0);
      check({tag, "_done"}, 32'(clr_done), 0);
   endtask

   task automatic pen_request(input logic [N-1:0] r, input logic [N-1:0] c,
                              input logic [DW-1:0] d);
      pen_row = r; pen_col = c; pen_data = d; pen_req = 1'b1;
   endtask

   initial begin
      model_reset();
      for (int i = 0; i < 64; i++) dut_ram[i] = '0;
      #3;
      check_reset_outputs("rst0");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Scan walk: rows and columns stepping through every position.
      for (int i = 0; i < 20; i++) begin
         scan_row = N'(1) << (i % 8);
         scan_col = N'(1) << ((i * 3) % 8);
         step();
      end

      // Valid pen write held until ack.
      pen_request(8'h04, 8'h10, 4'hA);
      repeat (6) step();

      // Bad pen addresses: zero and multi-hot column.
      pen_request(8'h04, 8'h00, 4'h3);
      repeat (5) step();
      pen_request(8'h04, 8'h03, 4'h3);
      repeat (5) step();

      // Bulk clear with a second clr_start at write 10.
      clr_data = 4'h8; clr_start = 1'b1;
      step();
      repeat (9) step();
      clr_start = 1'b1; clr_data = 4'h1;
      repeat (60) step();

      // Clear and pen at the same edge: clear runs first, pen lands after it.
      clr_data = 4'h5; clr_start = 1'b1;
      pen_request(8'h02, 8'h40, 4'hC);
      repeat (70) step();
      for (int i = 0; i < 64; i++) begin
         check($sformatf("ram_cell%0d", i), 32'(dut_ram[i]),
               (i == 1*8 + 6) ? 32'hC : 32'h5);
      end

      // Reset in the middle of a clear, with a pen request pending.
      clr_data = 4'h6; clr_start = 1'b1;
      step();
      pen_request(8'h01, 8'h01, 4'hF);
      repeat (29) step();
      rst_n = 1'b0;
      #2;
      check_reset_outputs("rst_mid");
      model_reset();
      pen_req = 1'b0;
      @(posedge clk);
      #1;
      check_reset_outputs("rst_hold");
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         scan_row = onehot_rand();
         scan_col = onehot_rand();
         step();
      end

      // Random traffic.
      for (int i = 0; i < 500; i++) begin
         scan_row = onehot_rand();
         scan_col = onehot_rand();
         if (!pen_req && $urandom_range(0, 3) == 0) begin
            if ($urandom_range(0, 4) == 0)
               pen_request(N'($urandom_range(0, 255)), N'($urandom_range(0, 255)),
                           DW'($urandom_range(0, 15)));
            else
               pen_request(onehot_rand(), onehot_rand(), DW'($urandom_range(0, 15)));
         end
         clr_start = ($urandom_range(0, 79) == 0);
         clr_data  = DW'($urandom_range(0, 15));
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/led_ram_arbiter.md
# led_ram_arbiter

Sequencer and arbiter for the single-port 8x8 LED display RAM. Shares the one RAM port among three requesters: the scan readout path (continuous reads), light-pen pixel writes (handshaked), and a bulk-clear sequencer that fills all 64 cells with one value (used on RST and erase-all). Sits between the scanner/pen front end and `led_ram`, and drives that RAM's `we`, `data`, `addr_row` and `addr_col` pins directly.

## Interface
- `N`, 8: rows = columns; row and column addresses are N-bit one-hot.
- `DATA_W`, 4: cell width; bit 3 = lit, bits 2:1 = colour, bit 0 reserved.
- `PEN_HOLDOFF`, 1: minimum number of scan-only cycles after each pen write; must be at least 1.
- `clk` in 1: system clock, single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `scan_row` / `scan_col` in N / N: current one-hot scan address from the scanner.
- `pen_req` in 1: pen write request; held until `pen_ack`.
- `pen_row` / `pen_col` in N / N: pen target address, one-hot; stable while `pen_req` is high.
- `pen_data` in DATA_W: value to write; stable while `pen_req` is high.
- `pen_ack` out 1: one-cycle pulse; the request has been consumed.
- `pen_err` out 1: one-cycle pulse together with `pen_ack` when the pen address was not one-hot; no write occurs.
- `clr_start` in 1: one-cycle pulse that starts a bulk clear.
- `clr_data` in DATA_W: fill value, sampled on the cycle `clr_start` is accepted.
- `clr_busy` out 1: high while the clear sequence is in progress.
- `clr_done` out 1: one-cycle pulse when the clear completes.
- `ram_we` out 1: RAM write enable.
- `ram_data` out DATA_W: RAM write data.
- `ram_row` / `ram_col` out N / N: RAM address, one-hot.
- `scan_valid` out 1: high when the current RAM address is the scan address, so RAM read data belongs to the scanner.

## Operation
- FSM has two states: IDLE (scan/pen arbitration) and CLEAR (bulk fill).
- Every decision is made on a clock edge, and all outputs are registered.
- Fixed priority: CLEAR first, then pen, then scan.
- IDLE, `clr_start` = 1:
  - Latch `clr_data`.
  - Reset the row and column counters (3 bits each) to 0.
  - Move to CLEAR.
  - The pen request is not served on this edge.
- IDLE, `pen_req` = 1, holdoff counter = 0, both addresses one-hot:
  - Drive `ram_we` = 1 with `pen_row`, `pen_col`, `pen_data`.
  - Pulse `pen_ack`.
  - Load the holdoff counter with `PEN_HOLDOFF`.
- IDLE, `pen_req` = 1, holdoff counter = 0, either address zero or multi-hot:
  - Pulse `pen_ack` and `pen_err`.
  - `ram_we` stays 0 and the scan address is driven.
  - Load the holdoff counter as in the valid case.
- Otherwise in IDLE: scan read.
  - `ram_we` = 0, `ram_row` = `scan_row`, `ram_col` = `scan_col`, `scan_valid` = 1.
  - The holdoff counter decrements if nonzero.
- During a scan cycle `pen_req` is ignored. The requester drops `pen_req` on the cycle it sees `pen_ack`.
- CLEAR:
  - Each cycle: `ram_we` = 1, `ram_row` = 1 << r, `ram_col` = 1 << c, `ram_data` = latched fill value.
  - Address order is row-major; c increments and wraps 7 -> 0, incrementing r.
  - After cell (7,7): return to IDLE and pulse `clr_done`.
  - `scan_valid` = 0 throughout, and the pen waits without an ack.
- `clr_start` while in CLEAR is ignored; the clear is not restarted.
- `rst_n` low at any time:
  - Immediately forces IDLE, with the counters and holdoff counter at 0.
  - A clear in progress is aborted with no `clr_done`.
  - A pending pen request is dropped with no ack.

## Timing
- Reset values: `ram_we` 0, `ram_data` 0, `ram_row` 0, `ram_col` 0, `scan_valid` 0, `pen_ack` 0, `pen_err` 0, `clr_busy` 0, `clr_done` 0, FSM IDLE.
- Latency from request edge to RAM pins is 1 cycle for all three requesters.
  - A scan address sampled at edge t appears on `ram_*` after edge t.
  - RAM read data then arrives per `led_ram` latency, qualified by the registered `scan_valid`.
- Pen request sampled at edge t, no holdoff:
  - `ram_we` and `pen_ack` are high in the same cycle, t+1.
  - Edges t+1 .. t+`PEN_HOLDOFF` are scan cycles regardless of `pen_req`.
  - The earliest next grant is at edge t+`PEN_HOLDOFF`+1.
- `clr_start` sampled at edge t:
  - `clr_busy` is high from t+1 through t+64.
  - Writes occur in cycles t+1 .. t+64 (exactly 64).
  - `clr_done` = 1 and `clr_busy` = 0 in cycle t+65.
  - Cycle t+65 is already an arbitrated IDLE slot.
- Simultaneous `clr_start` and `pen_req` at the same edge: the clear wins, and the pen is acked no earlier than t+65.
- The holdoff counter is held during CLEAR.

## Test plan
- Reset release, `pen_req` = 0, scan walking rows/cols: every cycle has `ram_we` = 0, `scan_valid` = 1, and `ram_row`/`ram_col` equal the scan address delayed by one cycle.
- Pen request (row 0x04, col 0x10, data 0xA) held until ack: exactly one cycle with `ram_we` = 1 and the same values, `pen_ack` in that cycle, then at least 1 scan cycle; `pen_err` stays 0.
- Pen request with `pen_col` = 0x00 and, separately, 0x03: `pen_ack` and `pen_err` pulse together and `ram_we` never rises.
- `clr_start` with `clr_data` = 0x8:
  - 64 consecutive writes in row-major order, ending at (0x80, 0x80).
  - `clr_busy` is high for 64 cycles and `clr_done` is high in cycle 65.
  - A second `clr_start` at write 10 has no effect.
- `clr_start` and `pen_req` at the same edge: the clear runs to completion first; the pen write lands in cycle t+65 and the RAM model shows the pen cell overwriting the fill value.
- `rst_n` pulsed low at clear write 30: all outputs return to their reset values immediately, no `clr_done` pulse occurs, and after release the arbiter resumes scan-only operation.
